// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-stage program-counter sequencer with return-address stack
module pc_sequencer #(
  parameter int ADDR_WIDTH   = 32,
  parameter int NUM_STAGES   = 4,
  parameter int PC_STEP      = 1,
  parameter int RESET_VECTOR = 0,
  parameter int STACK_DEPTH  = 4,
  localparam int SW  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int SPW = $clog2(STACK_DEPTH),
  localparam int DW  = SPW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic [2:0]            ctrl_op,
  input  logic [ADDR_WIDTH-1:0] cond_value,
  input  logic [ADDR_WIDTH-1:0] target_addr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [SW-1:0]         stage,
  output logic                  fetch_en,
  output logic                  commit_en,
  output logic                  redirect,
  output logic [DW-1:0]         stack_depth,
  output logic                  stack_err
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [SW-1:0]         r_stage;
  logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];
  logic [SPW-1:0]        r_sp;
  logic [DW-1:0]         r_depth;
  logic                  r_redirect;
  logic                  r_err;

  logic                  w_commit;
  logic                  w_full;
  logic                  w_empty;
  logic [ADDR_WIDTH-1:0] w_seq_pc;
  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_taken;
  logic                  w_err;

  assign w_commit = (r_stage == SW'(NUM_STAGES - 1)) && !stall;
  assign w_seq_pc = r_pc + ADDR_WIDTH'(PC_STEP);
  assign w_full   = (r_depth == DW'(STACK_DEPTH));
  assign w_empty  = (r_depth == '0);

  always_comb begin
    w_next_pc = w_seq_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_taken   = 1'b0;
    w_err     = 1'b0;
    case (ctrl_op)
      3'd1: begin
        w_next_pc = target_addr;
        w_taken   = 1'b1;
      end
      3'd2: begin
        if (cond_value != '0) begin
          w_next_pc = target_addr;
          w_taken   = 1'b1;
        end
      end
      3'd3: begin
        w_next_pc = target_addr;
        w_push    = 1'b1;
        w_taken   = 1'b1;
        w_err     = w_full;
      end
      3'd4: begin
        // An empty-stack return degrades to a sequential step and flags the error.
        if (!w_empty) begin
          w_next_pc = r_stack[r_sp - SPW'(1)];
          w_pop     = 1'b1;
          w_taken   = 1'b1;
        end else begin
          w_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= ADDR_WIDTH'(RESET_VECTOR);
      r_stage    <= '0;
      r_sp       <= '0;
      r_depth    <= '0;
      r_redirect <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_redirect <= w_commit && w_taken;
      if (!stall) begin
        r_stage <= w_commit ? '0 : r_stage + SW'(1);
      end
      if (w_commit) begin
        r_pc <= w_next_pc;
        // Full-stack push wraps the pointer onto the oldest entry; depth saturates.
        if (w_push) begin
          r_sp <= r_sp + SPW'(1);
          if (!w_full) r_depth <= r_depth + DW'(1);
        end
        if (w_pop) begin
          r_sp    <= r_sp - SPW'(1);
          r_depth <= r_depth - DW'(1);
        end
        if (w_err) r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_push) r_stack[r_sp] <= w_seq_pc;
  end

  assign pc          = r_pc;
  assign stage       = r_stage;
  assign fetch_en    = (r_stage == '0) && !stall;
  assign commit_en   = w_commit;
  assign redirect    = r_redirect;
  assign stack_depth = r_depth;
  assign stack_err   = r_err;

endmodule
